// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared state encoding, coin codes and coin value helper
package vending_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COLLECT  = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_CHANGE   = 2'd3
   } state_t;

   localparam logic [1:0] COIN_NONE = 2'd0;
   localparam logic [1:0] COIN_1    = 2'd1;
   localparam logic [1:0] COIN_2    = 2'd2;
   localparam logic [1:0] COIN_3    = 2'd3;

   // Credit value of a coin code for a given denomination set; COIN_NONE is worth nothing.
   function automatic int unsigned coin_value(input logic [1:0] code,
                                              input int unsigned val1,
                                              input int unsigned val2,
                                              input int unsigned val3);
      case (code)
         COIN_1:  return val1;
         COIN_2:  return val2;
         COIN_3:  return val3;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/change_selector.sv
// rtl/change_selector.sv - greedy pick of the largest coin that fits the remaining credit
module change_selector
   import vending_pkg::*;
#(
   parameter int unsigned VAL1     = 5,
   parameter int unsigned VAL2     = 10,
   parameter int unsigned VAL3     = 25,
   parameter int unsigned CREDIT_W = 7
) (
   input  logic [CREDIT_W-1:0] credit,
   output logic [1:0]          coin
);

   localparam logic [CREDIT_W-1:0] V1 = CREDIT_W'(VAL1);
   localparam logic [CREDIT_W-1:0] V2 = CREDIT_W'(VAL2);
   localparam logic [CREDIT_W-1:0] V3 = CREDIT_W'(VAL3);

   // Largest denomination first; credit is always a multiple of VAL1, so any nonzero credit yields a coin.
   always_comb begin
      coin = COIN_NONE;
      if (credit >= V3) begin
         coin = COIN_3;
      end else if (credit >= V2) begin
         coin = COIN_2;
      end else if (credit >= V1) begin
         coin = COIN_1;
      end
   end

endmodule

// File: rtl/vending_machine_change.sv
// rtl/vending_machine_change.sv - coin-accepting vending FSM with coin-by-coin change/refund
module vending_machine_change
   import vending_pkg::*;
#(
   parameter int unsigned PRICE    = 15,
   parameter int unsigned VAL1     = 5,
   parameter int unsigned VAL2     = 10,
   parameter int unsigned VAL3     = 25,
   parameter int unsigned CREDIT_W = 7
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          coin,
   input  logic                cancel,
   input  logic                change_ready,
   output logic                dispensed,
   output logic                coin_reject,
   output logic                change_valid,
   output logic [1:0]          change_coin,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit
);

   // The credit register must hold the worst-case overshoot: PRICE-1 already inserted plus the largest coin.
   if (PRICE - 1 + VAL3 >= (1 << CREDIT_W)) begin : g_credit_w_check
      $error("CREDIT_W too narrow to hold PRICE-1+VAL3");
   end
   if (!(VAL1 > 0 && VAL1 < VAL2 && VAL2 < VAL3 && (VAL2 % VAL1) == 0 &&
         (VAL3 % VAL1) == 0 && PRICE >= VAL1 && (PRICE % VAL1) == 0)) begin : g_denom_check
      $error("coin values or PRICE inconsistent");
   end

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

   state_t              state;
   state_t              next_state;
   logic [CREDIT_W-1:0] credit_q;
   logic [CREDIT_W-1:0] next_credit;
   logic                reject_q;
   logic                next_reject;
   logic [1:0]          sel_coin;
   logic [CREDIT_W-1:0] in_value;
   logic [CREDIT_W-1:0] paid_value;
   logic [CREDIT_W-1:0] sum;

   change_selector #(
      .VAL1     (VAL1),
      .VAL2     (VAL2),
      .VAL3     (VAL3),
      .CREDIT_W (CREDIT_W)
   ) u_change_selector (
      .credit (credit_q),
      .coin   (sel_coin)
   );

   // State, credit and reject flag; reset discards any owed change.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         credit_q <= '0;
         reject_q <= 1'b0;
      end else begin
         state    <= next_state;
         credit_q <= next_credit;
         reject_q <= next_reject;
      end
   end

   // Next-state and credit arithmetic; a price-reaching coin beats a same-edge cancel.
   always_comb begin
      next_state  = state;
      next_credit = credit_q;
      next_reject = 1'b0;
      in_value    = CREDIT_W'(coin_value(coin, VAL1, VAL2, VAL3));
      paid_value  = CREDIT_W'(coin_value(sel_coin, VAL1, VAL2, VAL3));
      sum         = credit_q + in_value;
      case (state)
         ST_IDLE, ST_COLLECT: begin
            if (coin != COIN_NONE && sum >= PRICE_C) begin
               next_state  = ST_DISPENSE;
               next_credit = sum - PRICE_C;
            end else if (cancel) begin
               if (sum != '0) begin
                  next_state  = ST_CHANGE;
                  next_credit = sum;
               end else begin
                  next_state  = ST_IDLE;
                  next_credit = '0;
               end
            end else if (coin != COIN_NONE) begin
               next_state  = ST_COLLECT;
               next_credit = sum;
            end
         end
         ST_DISPENSE: begin
            next_reject = (coin != COIN_NONE);
            next_state  = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
         end
         ST_CHANGE: begin
            next_reject = (coin != COIN_NONE);
            if (change_ready) begin
               next_credit = credit_q - paid_value;
               if (credit_q == paid_value) begin
                  next_state = ST_IDLE;
               end
            end
         end
         default: begin
            next_state  = ST_IDLE;
            next_credit = '0;
         end
      endcase
   end

   // Outputs are decoded from registered state and credit only.
   always_comb begin
      dispensed    = (state == ST_DISPENSE);
      busy         = (state == ST_DISPENSE) || (state == ST_CHANGE);
      change_valid = (state == ST_CHANGE);
      change_coin  = (state == ST_CHANGE) ? sel_coin : COIN_NONE;
      coin_reject  = reject_q;
      credit       = credit_q;
   end

endmodule

// File: tb/tb_vending_machine_change.sv
// tb/tb_vending_machine_change.sv - directed self-checking bench for vending_machine_change
module tb_vending_machine_change;

   logic       clock;
   logic       reset;
   logic [1:0] coin;
   logic       cancel;
   logic       change_ready;
   logic       dispensed;
   logic       coin_reject;
   logic       change_valid;
   logic [1:0] change_coin;
   logic       busy;
   logic [6:0] credit;

   logic [1:0] p_coin;
   logic       p_cancel;
   logic       p_change_ready;
   logic       p_dispensed;
   logic       p_coin_reject;
   logic       p_change_valid;
   logic [1:0] p_change_coin;
   logic       p_busy;
   logic [6:0] p_credit;

   int checks;
   int errors;

   vending_machine_change dut (
      .clock        (clock),
      .reset        (reset),
      .coin         (coin),
      .cancel       (cancel),
      .change_ready (change_ready),
      .dispensed    (dispensed),
      .coin_reject  (coin_reject),
      .change_valid (change_valid),
      .change_coin  (change_coin),
      .busy         (busy),
      .credit       (credit)
   );

   vending_machine_change #(
      .PRICE    (20),
      .VAL1     (5),
      .VAL2     (10),
      .VAL3     (50),
      .CREDIT_W (7)
   ) dut_p (
      .clock        (clock),
      .reset        (reset),
      .coin         (p_coin),
      .cancel       (p_cancel),
      .change_ready (p_change_ready),
      .dispensed    (p_dispensed),
      .coin_reject  (p_coin_reject),
      .change_valid (p_change_valid),
      .change_coin  (p_change_coin),
      .busy         (p_busy),
      .credit       (p_credit)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      checks++;
      if ({dispensed, coin_reject, change_valid, change_coin, busy, credit} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%h want=0", {dispensed, coin_reject, change_valid, change_coin, busy, credit});
      end
      checks++;
      if ({p_dispensed, p_change_valid, p_busy, p_credit} !== 10'd0) begin
         errors++;
         $display("FAIL reset_outputs_p got=%h want=0", {p_dispensed, p_change_valid, p_busy, p_credit});
      end
   endtask

   task automatic test_exact_price();
      coin = 2'd1;
      step();
      checks++;
      if (credit !== 7'd5) begin errors++; $display("FAIL exact_credit5 got=%0d want=5", credit); end
      step();
      checks++;
      if (credit !== 7'd10) begin errors++; $display("FAIL exact_credit10 got=%0d want=10", credit); end
      step();
      coin = 2'd0;
      checks++;
      if ({dispensed, busy, credit} !== {1'b1, 1'b1, 7'd0}) begin
         errors++; $display("FAIL exact_dispense got disp=%b busy=%b credit=%0d want 1 1 0", dispensed, busy, credit);
      end
      step();
      checks++;
      if ({dispensed, busy, change_valid, credit} !== 10'd0) begin
         errors++; $display("FAIL exact_idle got disp=%b busy=%b cv=%b credit=%0d want 0 0 0 0", dispensed, busy, change_valid, credit);
      end
   endtask

   task automatic test_back_to_back();
      coin = 2'd3;
      step();
      coin = 2'd0;
      checks++;
      if ({dispensed, credit} !== {1'b1, 7'd10}) begin
         errors++; $display("FAIL b2b_dispense got disp=%b credit=%0d want 1 10", dispensed, credit);
      end
      change_ready = 1'b1;
      step();
      checks++;
      if ({change_valid, change_coin} !== {1'b1, 2'd2}) begin
         errors++; $display("FAIL b2b_change got cv=%b coin=%0d want 1 2", change_valid, change_coin);
      end
      step();
      change_ready = 1'b0;
      checks++;
      if ({change_valid, busy, credit} !== 9'd0) begin
         errors++; $display("FAIL b2b_idle got cv=%b busy=%b credit=%0d want 0 0 0", change_valid, busy, credit);
      end
   endtask

   task automatic test_change();
      coin = 2'd2;
      step();
      coin = 2'd3;
      step();
      coin = 2'd0;
      change_ready = 1'b1;
      checks++;
      if ({dispensed, credit} !== {1'b1, 7'd20}) begin
         errors++; $display("FAIL chg_dispense got disp=%b credit=%0d want 1 20", dispensed, credit);
      end
      step();
      checks++;
      if ({dispensed, change_valid, change_coin, credit} !== {1'b0, 1'b1, 2'd2, 7'd20}) begin
         errors++; $display("FAIL chg_first got disp=%b cv=%b coin=%0d credit=%0d want 0 1 2 20", dispensed, change_valid, change_coin, credit);
      end
      step();
      checks++;
      if ({change_valid, change_coin, credit} !== {1'b1, 2'd2, 7'd10}) begin
         errors++; $display("FAIL chg_second got cv=%b coin=%0d credit=%0d want 1 2 10", change_valid, change_coin, credit);
      end
      step();
      change_ready = 1'b0;
      checks++;
      if ({change_valid, change_coin, busy, credit} !== 11'd0) begin
         errors++; $display("FAIL chg_idle got cv=%b coin=%0d busy=%b credit=%0d want 0 0 0 0", change_valid, change_coin, busy, credit);
      end
   endtask

   task automatic test_stall();
      coin = 2'd2;
      step();
      coin = 2'd3;
      step();
      coin = 2'd0;
      step();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({change_valid, change_coin, credit} !== {1'b1, 2'd2, 7'd20}) begin
            errors++; $display("FAIL stall_hold%0d got cv=%b coin=%0d credit=%0d want 1 2 20", i, change_valid, change_coin, credit);
         end
         step();
      end
      change_ready = 1'b1;
      step();
      checks++;
      if ({change_valid, change_coin, credit} !== {1'b1, 2'd2, 7'd10}) begin
         errors++; $display("FAIL stall_release got cv=%b coin=%0d credit=%0d want 1 2 10", change_valid, change_coin, credit);
      end
      step();
      change_ready = 1'b0;
      checks++;
      if ({change_valid, credit} !== 8'd0) begin
         errors++; $display("FAIL stall_idle got cv=%b credit=%0d want 0 0", change_valid, credit);
      end
   endtask

   task automatic test_cancel();
      coin = 2'd2;
      step();
      coin = 2'd1;
      cancel = 1'b1;
      step();
      coin = 2'd0;
      cancel = 1'b0;
      checks++;
      if ({dispensed, credit} !== {1'b1, 7'd0}) begin
         errors++; $display("FAIL cancel_purchase got disp=%b credit=%0d want 1 0", dispensed, credit);
      end
      step();
      checks++;
      if ({change_valid, busy} !== 2'b00) begin
         errors++; $display("FAIL cancel_no_refund got cv=%b busy=%b want 0 0", change_valid, busy);
      end
      coin = 2'd1;
      step();
      coin = 2'd0;
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      checks++;
      if ({dispensed, change_valid, change_coin, credit} !== {1'b0, 1'b1, 2'd1, 7'd5}) begin
         errors++; $display("FAIL cancel_refund got disp=%b cv=%b coin=%0d credit=%0d want 0 1 1 5", dispensed, change_valid, change_coin, credit);
      end
      change_ready = 1'b1;
      step();
      change_ready = 1'b0;
      checks++;
      if ({change_valid, credit} !== 8'd0) begin
         errors++; $display("FAIL cancel_refund_done got cv=%b credit=%0d want 0 0", change_valid, credit);
      end
   endtask

   task automatic test_reject();
      coin = 2'd2;
      step();
      coin = 2'd3;
      step();
      coin = 2'd2;
      step();
      coin = 2'd0;
      checks++;
      if ({coin_reject, change_valid, credit} !== {1'b1, 1'b1, 7'd20}) begin
         errors++; $display("FAIL reject_dispense got rej=%b cv=%b credit=%0d want 1 1 20", coin_reject, change_valid, credit);
      end
      step();
      checks++;
      if (coin_reject !== 1'b0) begin errors++; $display("FAIL reject_pulse_width got=%b want=0", coin_reject); end
      coin = 2'd2;
      step();
      coin = 2'd0;
      checks++;
      if ({coin_reject, credit} !== {1'b1, 7'd20}) begin
         errors++; $display("FAIL reject_change got rej=%b credit=%0d want 1 20", coin_reject, credit);
      end
      change_ready = 1'b1;
      step(2);
      change_ready = 1'b0;
      checks++;
      if ({busy, credit} !== 8'd0) begin
         errors++; $display("FAIL reject_idle got busy=%b credit=%0d want 0 0", busy, credit);
      end
   endtask

   task automatic test_mid_reset();
      coin = 2'd2;
      step();
      coin = 2'd3;
      step();
      coin = 2'd0;
      step();
      checks++;
      if ({change_valid, credit} !== {1'b1, 7'd20}) begin
         errors++; $display("FAIL midrst_setup got cv=%b credit=%0d want 1 20", change_valid, credit);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({change_valid, change_coin, busy, credit} !== 11'd0) begin
         errors++; $display("FAIL midrst_idle got cv=%b coin=%0d busy=%b credit=%0d want 0 0 0 0", change_valid, change_coin, busy, credit);
      end
   endtask

   task automatic test_param_instance();
      p_coin = 2'd3;
      step();
      p_coin = 2'd0;
      p_change_ready = 1'b1;
      checks++;
      if ({p_dispensed, p_credit} !== {1'b1, 7'd30}) begin
         errors++; $display("FAIL p_dispense got disp=%b credit=%0d want 1 30", p_dispensed, p_credit);
      end
      step();
      checks++;
      if ({p_change_valid, p_change_coin, p_credit} !== {1'b1, 2'd2, 7'd30}) begin
         errors++; $display("FAIL p_change30 got cv=%b coin=%0d credit=%0d want 1 2 30", p_change_valid, p_change_coin, p_credit);
      end
      step();
      checks++;
      if ({p_change_coin, p_credit} !== {2'd2, 7'd20}) begin
         errors++; $display("FAIL p_change20 got coin=%0d credit=%0d want 2 20", p_change_coin, p_credit);
      end
      step();
      checks++;
      if ({p_change_coin, p_credit} !== {2'd2, 7'd10}) begin
         errors++; $display("FAIL p_change10 got coin=%0d credit=%0d want 2 10", p_change_coin, p_credit);
      end
      step();
      p_change_ready = 1'b0;
      checks++;
      if ({p_change_valid, p_busy, p_credit} !== 9'd0) begin
         errors++; $display("FAIL p_idle got cv=%b busy=%b credit=%0d want 0 0 0", p_change_valid, p_busy, p_credit);
      end
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      reset          = 1'b1;
      coin           = 2'd0;
      cancel         = 1'b0;
      change_ready   = 1'b0;
      p_coin         = 2'd0;
      p_cancel       = 1'b0;
      p_change_ready = 1'b0;
      test_reset();
      test_exact_price();
      test_back_to_back();
      test_change();
      test_stall();
      test_cancel();
      test_reject();
      test_mid_reset();
      test_param_instance();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
